// File: rtl/snn_pkg.sv
// Shared SNN parameters and types used by the spike injector and its bench.
package snn_pkg;

    parameter int T     = 4;
    parameter int N     = 8;
    parameter int ALPHA = 4;

    typedef struct packed {
        logic [$clog2(T)-1:0] block;
        logic [$clog2(N)-1:0] neuron;
    } spike_event_t;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        GAP
    } injector_state_t;

endpackage

// File: rtl/spike_injector.sv
// Converts a stream of {block, neuron} spike events into forced spikes on the
// SNN core, holding each one for ALPHA cycles followed by a single gap cycle.
module spike_injector
    import snn_pkg::*;
#(
    parameter int T     = snn_pkg::T,
    parameter int N     = snn_pkg::N,
    parameter int ALPHA = snn_pkg::ALPHA,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(T)+$clog2(N)-1:0]   s_tdata,
    input  logic                             s_tvalid,
    output logic                             s_tready,
    input  logic                             s_tlast,
    output logic                             time_step,
    output logic                             force_spike_en,
    output logic [$clog2(T)-1:0]             force_spike_block_select,
    output logic [$clog2(N)-1:0]             force_spike_neuron_select,
    output logic                             frame_done,
    output logic [CNT_W-1:0]                 event_count,
    output logic [CNT_W-1:0]                 drop_count
);

    localparam int BW = $clog2(T);
    localparam int NW = $clog2(N);
    localparam int CW = (ALPHA > 1) ? $clog2(ALPHA) : 1;
    localparam logic [31:0] T_LIMIT = 32'(T);
    localparam logic [31:0] N_LIMIT = 32'(N);

    injector_state_t state, state_next;
    logic [CW-1:0]   beat_cnt;
    logic            last_q;
    logic            accept;
    logic [BW-1:0]   blk_in;
    logic [NW-1:0]   nrn_in;
    logic            in_range;

    assign blk_in   = s_tdata[BW+NW-1:NW];
    assign nrn_in   = s_tdata[NW-1:0];
    // Non-power-of-two T or N leaves encodable addresses with no neuron behind them.
    assign in_range = (32'(blk_in) < T_LIMIT) && (32'(nrn_in) < N_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        s_tready       = 1'b0;
        accept         = 1'b0;
        force_spike_en = 1'b0;
        time_step      = 1'b0;
        frame_done     = 1'b0;
        case (state)
            IDLE: begin
                s_tready = ~reset;
                accept   = s_tvalid & ~reset;
                if (accept) state_next = in_range ? INJECT : GAP;
            end
            INJECT: begin
                force_spike_en = 1'b1;
                time_step      = 1'b1;
                if (beat_cnt == '0) state_next = GAP;
            end
            GAP: begin
                frame_done = last_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Selects only follow in-range events so the core never sees a bogus address.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt                  <= '0;
            last_q                    <= 1'b0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            event_count               <= '0;
            drop_count                <= '0;
        end else if (accept) begin
            last_q <= s_tlast;
            if (in_range) begin
                beat_cnt                  <= CW'(ALPHA - 1);
                force_spike_block_select  <= blk_in;
                force_spike_neuron_select <= nrn_in;
                if (event_count != '1) event_count <= event_count + 1'b1;
            end else begin
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end else if (state == INJECT && beat_cnt != '0) begin
            beat_cnt <= beat_cnt - 1'b1;
        end
    end

endmodule
